// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: IDLE/RUN/PAUSE FSM, tick prescaler,
// MM:SS BCD time counter and lap snapshot, all outputs registered.
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV = 100000000,
    parameter int unsigned PRE_W    = 27
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        start_1p,
    input  logic        clr_1p,
    input  logic        lap_1p,
    output logic [15:0] disp_bcd,
    output logic        running,
    output logic        paused,
    output logic        lap_active,
    output logic        tick,
    output logic        wrap
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    state_t             state_q, state_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [15:0]        time_q, time_d;
    logic [15:0]        snap_q, snap_d;
    logic               lap_q, lap_d;
    logic               tick_d, wrap_d;
    logic [15:0]        disp_q;
    logic               running_q, paused_q, tick_q, wrap_q;

    // Digit order {min_hi, min_lo, sec_hi, sec_lo}; MSB of result is the 59:59 rollover.
    function automatic logic [16:0] bcd_inc(input logic [15:0] t);
        logic [3:0] sl, sh, ml, mh;
        logic       w;
        sl = t[3:0];
        sh = t[7:4];
        ml = t[11:8];
        mh = t[15:12];
        w  = 1'b0;
        if (sl >= 4'd9) begin
            sl = 4'd0;
            if (sh >= 4'd5) begin
                sh = 4'd0;
                if (ml >= 4'd9) begin
                    ml = 4'd0;
                    if (mh >= 4'd5) begin
                        mh = 4'd0;
                        w  = 1'b1;
                    end else begin
                        mh = mh + 4'd1;
                    end
                end else begin
                    ml = ml + 4'd1;
                end
            end else begin
                sh = sh + 4'd1;
            end
        end else begin
            sl = sl + 4'd1;
        end
        return {w, mh, ml, sh, sl};
    endfunction

    // Next-state logic for FSM, prescaler, time counter and lap snapshot.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        time_d  = time_q;
        snap_d  = snap_q;
        lap_d   = lap_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                pre_d = {PRE_W{1'b0}};
                if (clr_1p) begin
                    time_d = 16'h0000;
                end else begin
                    time_d = time_q;
                end
                if (start_1p) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // A tick due on a pausing edge is still applied.
                if (pre_q == PRE_LAST) begin
                    pre_d            = {PRE_W{1'b0}};
                    tick_d           = 1'b1;
                    {wrap_d, time_d} = bcd_inc(time_q);
                end else begin
                    pre_d = pre_q + {{(PRE_W-1){1'b0}}, 1'b1};
                end
                if (lap_1p) begin
                    lap_d = ~lap_q;
                    if (!lap_q) begin
                        snap_d = time_q;
                    end else begin
                        snap_d = snap_q;
                    end
                end else begin
                    lap_d = lap_q;
                end
                if (start_1p) begin
                    state_d = ST_PAUSE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (clr_1p) begin
                    state_d = ST_IDLE;
                    pre_d   = {PRE_W{1'b0}};
                    time_d  = 16'h0000;
                    snap_d  = 16'h0000;
                    lap_d   = 1'b0;
                end else begin
                    if (lap_1p) begin
                        lap_d = 1'b0;
                    end else begin
                        lap_d = lap_q;
                    end
                    if (start_1p) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_PAUSE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                pre_d   = {PRE_W{1'b0}};
                time_d  = 16'h0000;
                snap_d  = 16'h0000;
                lap_d   = 1'b0;
            end
        endcase
    end

    // State registers plus output registers derived from next-state values.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= ST_IDLE;
            pre_q     <= {PRE_W{1'b0}};
            time_q    <= 16'h0000;
            snap_q    <= 16'h0000;
            lap_q     <= 1'b0;
            disp_q    <= 16'h0000;
            running_q <= 1'b0;
            paused_q  <= 1'b0;
            tick_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            time_q    <= time_d;
            snap_q    <= snap_d;
            lap_q     <= lap_d;
            disp_q    <= lap_d ? snap_d : time_d;
            running_q <= (state_d == ST_RUN);
            paused_q  <= (state_d == ST_PAUSE);
            tick_q    <= tick_d;
            wrap_q    <= wrap_d;
        end
    end

    assign disp_bcd   = disp_q;
    assign running    = running_q;
    assign paused     = paused_q;
    assign lap_active = lap_q;
    assign tick       = tick_q;
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: seconds-level reference model,
// per-cycle compare process, directed literal checks and random pulses.
module tb_stopwatch_ctrl;

    localparam int TICK_DIV = 4;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        start_1p = 1'b0;
    logic        clr_1p = 1'b0;
    logic        lap_1p = 1'b0;
    logic [15:0] disp_bcd;
    logic        running, paused, lap_active, tick, wrap;

    int total = 0;
    int bad = 0;

    // Reference model: mode 0 idle, 1 run, 2 pause; time as whole seconds.
    int m_mode = 0;
    int m_frac = 0;
    int m_secs = 0;
    int m_snap = 0;
    bit m_lap  = 1'b0;
    bit m_tick = 1'b0;
    bit m_wrap = 1'b0;

    stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .PRE_W(3)) dut (
        .clk(clk), .clr_n(clr_n), .start_1p(start_1p), .clr_1p(clr_1p),
        .lap_1p(lap_1p), .disp_bcd(disp_bcd), .running(running),
        .paused(paused), .lap_active(lap_active), .tick(tick), .wrap(wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int s);
        int mn, sc;
        mn = s / 60;
        sc = s % 60;
        return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10)};
    endfunction

    function automatic void model_reset();
        m_mode = 0; m_frac = 0; m_secs = 0; m_snap = 0;
        m_lap = 1'b0; m_tick = 1'b0; m_wrap = 1'b0;
    endfunction

    function automatic void model_step(input bit s, input bit c, input bit l);
        int old;
        old = m_secs;
        m_tick = 1'b0;
        m_wrap = 1'b0;
        case (m_mode)
            0: begin
                m_frac = 0;
                if (c) m_secs = 0;
                if (s) m_mode = 1;
            end
            1: begin
                m_frac = m_frac + 1;
                if (m_frac == TICK_DIV) begin
                    m_frac = 0;
                    m_tick = 1'b1;
                    m_secs = (m_secs + 1) % 3600;
                    m_wrap = (m_secs == 0);
                end
                if (l) begin
                    if (!m_lap) m_snap = old;
                    m_lap = !m_lap;
                end
                if (s) m_mode = 2;
            end
            2: begin
                if (c) begin
                    m_mode = 0; m_frac = 0; m_secs = 0; m_snap = 0; m_lap = 1'b0;
                end else begin
                    if (l) m_lap = 1'b0;
                    if (s) m_mode = 1;
                end
            end
            default: model_reset();
        endcase
    endfunction

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        chk16("disp", disp_bcd, to_bcd(m_lap ? m_snap : m_secs));
        chk1("running", running, m_mode == 1);
        chk1("paused", paused, m_mode == 2);
        chk1("lap_active", lap_active, m_lap);
        chk1("tick", tick, m_tick);
        chk1("wrap", wrap, m_wrap);
        chk1("run_pause_excl", running & paused, 1'b0);
    end

    task automatic cyc(input bit s, input bit c, input bit l);
        start_1p = s;
        clr_1p   = c;
        lap_1p   = l;
        @(posedge clk);
        if (clr_n) model_step(s, c, l);
        else model_reset();
        @(negedge clk);
        start_1p = 1'b0;
        clr_1p   = 1'b0;
        lap_1p   = 1'b0;
    endtask

    task automatic run_until(input int target, input int limit);
        int n;
        n = 0;
        while (m_secs != target && n < limit) begin
            cyc(1'b0, 1'b0, 1'b0);
            n++;
        end
        total++;
        if (m_secs != target) begin
            bad++;
            $display("FAIL run_until: got %0d s expected %0d s", m_secs, target);
        end
    endtask

    task automatic async_reset_check();
        #2 clr_n = 1'b0;
        #1;
        model_reset();
        chk16("async_disp", disp_bcd, 16'h0000);
        chk1("async_running", running, 1'b0);
        chk1("async_paused", paused, 1'b0);
        chk1("async_lap", lap_active, 1'b0);
        chk1("async_tick", tick, 1'b0);
        chk1("async_wrap", wrap, 1'b0);
        @(negedge clk);
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    initial begin
        // Reset and idle.
        repeat (3) @(negedge clk);
        clr_n = 1'b1;
        repeat (50) cyc(1'b0, 1'b0, 1'b0);
        chk16("idle_disp", disp_bcd, 16'h0000);
        chk1("idle_running", running, 1'b0);

        // First ticks exactly TICK_DIV cycles after running rises.
        cyc(1'b1, 1'b0, 1'b0);
        chk1("start_running", running, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            repeat (TICK_DIV - 1) cyc(1'b0, 1'b0, 1'b0);
            chk1("pre_tick", tick, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
            chk1("tick_due", tick, 1'b1);
            chk16("tick_disp", disp_bcd, 16'(k));
        end

        // Pause keeps the fractional second.
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        repeat (20) cyc(1'b0, 1'b0, 1'b0);
        chk16("pause_hold", disp_bcd, 16'h0003);
        chk1("pause_flag", paused, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk1("resume_tick", tick, 1'b1);
        chk16("resume_disp", disp_bcd, 16'h0004);

        // Lap freeze while live time keeps counting.
        run_until(12, 200);
        cyc(1'b0, 1'b0, 1'b1);
        chk1("lap_set", lap_active, 1'b1);
        run_until(15, 200);
        chk16("lap_frozen", disp_bcd, 16'h0012);
        cyc(1'b0, 1'b0, 1'b1);
        chk16("lap_release", disp_bcd, 16'h0015);

        // In PAUSE, clear beats start.
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        chk16("clr_disp", disp_bcd, 16'h0000);
        chk1("clr_lap", lap_active, 1'b0);
        chk1("clr_running", running, 1'b0);

        // Async reset mid-run.
        cyc(1'b1, 1'b0, 1'b0);
        repeat (9) cyc(1'b0, 1'b0, 1'b0);
        async_reset_check();

        // Carry and wrap.
        cyc(1'b1, 1'b1, 1'b0);
        run_until(599, 4000);
        chk16("pre_carry", disp_bcd, 16'h0959);
        run_until(600, 20);
        chk16("carry", disp_bcd, 16'h1000);
        run_until(3599, 15000);
        chk16("pre_wrap", disp_bcd, 16'h5959);
        run_until(0, 20);
        chk16("wrap_disp", disp_bcd, 16'h0000);
        chk1("wrap_tick", tick, 1'b1);
        chk1("wrap_pulse", wrap, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        chk1("wrap_one_cycle", wrap, 1'b0);

        // Random pulses, including held and coincident ones.
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(11) == 0, $urandom_range(15) == 0, $urandom_range(9) == 0);
            if ($urandom_range(499) == 0) async_reset_check();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Sequencing controller for the Basys3 stopwatch. It consumes the single-cycle button pulses produced by the debounce stages and runs the IDLE/RUN/PAUSE state machine. It also owns the 1 Hz prescaler and the MM:SS BCD time counter, and holds a lap snapshot. Its outputs feed the 7-segment display driver and the status LEDs.

Parameters:
TICK_DIV, 100000000, clk cycles per time increment (1 Hz at 100 MHz); minimum 2
PRE_W, 27, prescaler width; must satisfy 2^PRE_W >= TICK_DIV

Ports:
clk  input  1  system clock, all logic on posedge
clr_n  input  1  asynchronous active-low reset
start_1p  input  1  one-cycle pulse from debounce, start/stop button
clr_1p  input  1  one-cycle pulse from debounce, clear button
lap_1p  input  1  one-cycle pulse from debounce, lap button
disp_bcd  output  16  {min_hi, min_lo, sec_hi, sec_lo}, 4 bits each, to display driver
running  output  1  high in RUN
paused  output  1  high in PAUSE
lap_active  output  1  display frozen on lap snapshot
tick  output  1  one-cycle pulse on each time increment
wrap  output  1  one-cycle pulse on the 59:59 -> 00:00 increment

Behaviour:
- Reset (clr_n low, async): state IDLE, prescaler 0, time 00:00, snapshot 00:00, lap_active 0. All outputs read 0 (disp_bcd 16'h0000).
- All outputs are registered. Any pulse sampled on edge N is visible on outputs after edge N.
- Inputs are level-sampled each cycle. There is no edge detection here, so a held input acts on every cycle.
- FSM, IDLE:
  - start_1p -> RUN.
  - clr_1p -> stay IDLE and re-zero time and prescaler.
  - lap_1p is ignored.
- FSM, RUN:
  - start_1p -> PAUSE.
  - clr_1p is ignored.
  - lap_1p toggles lap_active. Rising lap_active copies the live time into the snapshot on the same edge.
- FSM, PAUSE:
  - start_1p -> RUN.
  - clr_1p -> IDLE: zero time, prescaler and snapshot; lap_active <= 0.
  - lap_1p toggles lap_active. It only releases an existing freeze and never sets a new one in PAUSE.
- Simultaneous pulses:
  - In PAUSE, clr_1p beats start_1p: go to IDLE, not RUN.
  - In RUN, start_1p and lap_1p both act on the same edge.
  - In IDLE, start_1p and clr_1p together: go to RUN from zeroed counters.
- Prescaler:
  - Increments only in RUN and holds its value in PAUSE, so resume keeps the fractional second.
  - Zeroed in IDLE.
  - When prescaler == TICK_DIV-1 in RUN, it returns to 0, tick pulses, and the time increments on that edge.
- Timing of the first tick:
  - After start from IDLE, the first tick is exactly TICK_DIV cycles after running rises.
  - A start_1p that leaves RUN on the same edge as a due tick still applies that tick.
- Time counter, BCD:
  - sec_lo 0-9 carries into sec_hi 0-5, which carries into min_lo 0-9, which carries into min_hi 0-5.
  - 59:59 + 1 -> 00:00 with a wrap pulse coincident with tick; counting continues.
  - No digit ever holds a value above its limit.
- Display select: disp_bcd = lap_active ? snapshot : live time. The live time keeps counting while frozen.
- Status outputs: running = (state==RUN); paused = (state==PAUSE). Never both high.
- Reset mid-operation: clr_n asserted at any cycle forces the reset values immediately, without waiting for a clock edge.

Test Plan:
1. Reset release, no pulses, 50 cycles -> disp_bcd 0000; running, paused, tick and wrap all 0.
2. TICK_DIV=4, start_1p at edge 10 -> running high from edge 10; tick at edges 14, 18, 22; disp_bcd 0001, 0002, 0003.
3. TICK_DIV=4, run 2 ticks, start_1p (pause) for 20 cycles, start_1p again -> disp_bcd holds 0002 while paused; next tick arrives after the remaining prescaler count, not a full 4.
4. TICK_DIV=2, run to 5959 then one more tick -> disp_bcd 0000 with tick=1 and wrap=1 on the same cycle. Also check 0959 -> 1000 carry.
5. In RUN at 0012, lap_1p -> lap_active=1 and disp_bcd stays 0012 while live time reaches 0015. Second lap_1p -> disp_bcd 0015.
6. In PAUSE with lap_active=1, start_1p and clr_1p on the same edge -> IDLE, disp_bcd 0000, lap_active 0, running 0. Then assert clr_n mid-RUN -> all outputs zero without a clock edge.
